mem_stage_ctrl: RTL and testbench

Memory-access stage that sits directly downstream of the EX/MEM pipeline register. It consumes that register's outputs and drives the data memory through a variable-latency req/ack handshake, stalling upstream while an access is outstanding. It resolves branch/jump redirects and loads the MEM/WB pipeline register. Word accesses only; misaligned addresses and memory timeouts are trapped.

---
 rtl/mem_stage_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage controller.
// Sits behind the EX/MEM register: issues word loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, abandons an
// access after TIMEOUT wait cycles, resolves branch/jump redirects and loads
// the MEM/WB register. State changes on the falling clock edge to line up
// with the surrounding pipeline registers.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [31:0] ALUresult,
    input  logic [4:0]  Wreg_addr,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        JtoPC,
    input  logic        Branch,
    input  logic        zero,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] next_PC,
    input  logic [31:0] DM_Write_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_PC,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg,
    output logic [4:0]  wb_Wreg_addr,
    output logic [31:0] wb_ALUresult,
    output logic [31:0] wb_read_data,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;

    logic mem_op;
    logic mis;
    logic last_cnt;

    // next_PC travels with the instruction but this stage never needs it.
    logic unused_next_pc;
    assign unused_next_pc = ^next_PC;

    // Decode the current instruction and derive stall/redirect combinationally.
    always_comb begin
        mem_op   = in_valid & (MemRead | MemWrite);
        mis      = mem_op & (ALUresult[1:0] != 2'b00);
        last_cnt = (counter == CNT_W'(TIMEOUT - 1));

        if (state == IDLE)
            stall = mem_op & ~mis;
        else
            stall = ~(dm_ack | last_cnt);

        redirect    = in_valid & ~stall & (JtoPC | (Branch & zero));
        redirect_PC = JtoPC ? jump_addr : Branch_addr;
    end

    // Access FSM, memory interface registers, MEM/WB register and sticky errors.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            counter      <= '0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
            wb_Wreg_addr <= '0;
            wb_ALUresult <= '0;
            wb_read_data <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op & ~mis) begin
                        // Issue: address/data/direction stay frozen for the whole wait.
                        dm_req      <= 1'b1;
                        dm_we       <= MemWrite;
                        dm_addr     <= ALUresult;
                        dm_wdata    <= DM_Write_data;
                        counter     <= '0;
                        state       <= WAIT;
                        wb_valid    <= 1'b0;
                        wb_RegWrite <= 1'b0;
                    end else begin
                        // Non-memory op or trapped misaligned access retires in one edge.
                        wb_valid     <= in_valid;
                        wb_RegWrite  <= RegWrite & ~mis;
                        wb_MemtoReg  <= MemtoReg;
                        wb_Wreg_addr <= Wreg_addr;
                        wb_ALUresult <= ALUresult;
                        wb_read_data <= '0;
                        if (mis)
                            err_misalign <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dm_ack | last_cnt) begin
                        // Ack wins over a timeout landing in the same cycle.
                        state        <= IDLE;
                        dm_req       <= 1'b0;
                        counter      <= '0;
                        wb_valid     <= in_valid;
                        wb_RegWrite  <= RegWrite & dm_ack;
                        wb_MemtoReg  <= MemtoReg;
                        wb_Wreg_addr <= Wreg_addr;
                        wb_ALUresult <= ALUresult;
                        wb_read_data <= (dm_ack & ~dm_we) ? dm_rdata : 32'h0;
                        if (~dm_ack)
                            err_timeout <= 1'b1;
                    end else begin
                        // Still waiting: push a bubble so nothing is written back twice.
                        counter     <= counter + CNT_W'(1);
                        wb_valid    <= 1'b0;
                        wb_RegWrite <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl. Each instruction is
// described as a transaction (fields plus an ack delay); the expected
// completion cycle, stall profile and writeback contents are computed from
// that description.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] ALUresult = '0;
    logic [4:0]  Wreg_addr = '0;
    logic        RegWrite = 1'b0, MemWrite = 1'b0, MemRead = 1'b0, MemtoReg = 1'b0;
    logic        JtoPC = 1'b0, Branch = 1'b0, zero = 1'b0;
    logic [31:0] Branch_addr = '0, jump_addr = '0, next_PC = '0, DM_Write_data = '0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic        stall, redirect;
    logic [31:0] redirect_PC;
    logic        wb_valid, wb_RegWrite, wb_MemtoReg;
    logic [4:0]  wb_Wreg_addr;
    logic [31:0] wb_ALUresult, wb_read_data;
    logic        err_misalign, err_timeout;

    int n_vec = 0;
    int n_err = 0;

    // Sticky error flags as the model expects them.
    logic exp_mis_flag = 1'b0;
    logic exp_to_flag  = 1'b0;

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic [4:0]  wa;
        logic        rw, mw, mr, m2r, j, br, z;
        logic [31:0] baddr, jaddr, wdata;
        int          d;
    } instr_t;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .ALUresult(ALUresult),
        .Wreg_addr(Wreg_addr), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemtoReg(MemtoReg), .JtoPC(JtoPC), .Branch(Branch),
        .zero(zero), .Branch_addr(Branch_addr), .jump_addr(jump_addr),
        .next_PC(next_PC), .DM_Write_data(DM_Write_data), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
        .redirect(redirect), .redirect_PC(redirect_PC), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_Wreg_addr(wb_Wreg_addr), .wb_ALUresult(wb_ALUresult),
        .wb_read_data(wb_read_data), .err_misalign(err_misalign),
        .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dm_req"}, 32'(dm_req), 0);
        check({tag, "_dm_we"}, 32'(dm_we), 0);
        check({tag, "_dm_addr"}, dm_addr, 0);
        check({tag, "_dm_wdata"}, dm_wdata, 0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 0);
        check({tag, "_wb_regwrite"}, 32'(wb_RegWrite), 0);
        check({tag, "_wb_memtoreg"}, 32'(wb_MemtoReg), 0);
        check({tag, "_wb_waddr"}, 32'(wb_Wreg_addr), 0);
        check({tag, "_wb_alu"}, wb_ALUresult, 0);
        check({tag, "_wb_rdata"}, wb_read_data, 0);
        check({tag, "_err_mis"}, 32'(err_misalign), 0);
        check({tag, "_err_to"}, 32'(err_timeout), 0);
    endtask

    // Apply one instruction, hold it while the model says stall, check each cycle.
    task automatic run_instr(input instr_t t);
        logic        memop, mis, acc, tout, exp_stall, exp_redir;
        logic [31:0] ack_data;
        int          c;
        memop = t.v & (t.mr | t.mw);
        mis   = memop & (t.alu[1:0] != 2'b00);
        acc   = memop & ~mis;
        c     = acc ? ((t.d + 1 < TIMEOUT) ? t.d + 1 : TIMEOUT) : 0;
        tout  = acc && (t.d + 1 > TIMEOUT);
        ack_data = '0;

        @(posedge CLK); #1;
        in_valid = t.v; ALUresult = t.alu; Wreg_addr = t.wa;
        RegWrite = t.rw; MemWrite = t.mw; MemRead = t.mr; MemtoReg = t.m2r;
        JtoPC = t.j; Branch = t.br; zero = t.z;
        Branch_addr = t.baddr; jump_addr = t.jaddr; DM_Write_data = t.wdata;
        next_PC = $urandom;

        for (int k = 0; k <= c; k++) begin
            if (k > 0) begin
                @(posedge CLK); #1;
            end
            dm_ack   = acc ? (k == t.d + 1) : ($urandom_range(0, 3) == 0);
            dm_rdata = $urandom;
            if (acc && k == t.d + 1) ack_data = dm_rdata;
            #1;
            exp_stall = (k < c);
            exp_redir = t.v & ~exp_stall & (t.j | (t.br & t.z));
            check("stall", 32'(stall), 32'(exp_stall));
            check("redirect", 32'(redirect), 32'(exp_redir));
            if (exp_redir)
                check("redirect_pc", redirect_PC, t.j ? t.jaddr : t.baddr);
            check("dm_req", 32'(dm_req), 32'(acc && k >= 1));
            if (acc && k >= 1) begin
                check("dm_addr", dm_addr, t.alu);
                check("dm_we", 32'(dm_we), 32'(t.mw));
                check("dm_wdata", dm_wdata, t.wdata);
            end

            @(negedge CLK); #1;
            if (k < c) begin
                check("bubble_valid", 32'(wb_valid), 0);
                check("bubble_regwrite", 32'(wb_RegWrite), 0);
            end else begin
                exp_mis_flag = exp_mis_flag | mis;
                exp_to_flag  = exp_to_flag | tout;
                check("wb_valid", 32'(wb_valid), 32'(t.v));
                check("wb_regwrite", 32'(wb_RegWrite), 32'(t.rw & ~mis & ~tout));
                check("wb_memtoreg", 32'(wb_MemtoReg), 32'(t.m2r));
                check("wb_waddr", 32'(wb_Wreg_addr), 32'(t.wa));
                check("wb_alu", wb_ALUresult, t.alu);
                check("wb_rdata", wb_read_data, (acc && !tout && !t.mw) ? ack_data : 32'h0);
            end
            check("err_misalign", 32'(err_misalign), 32'(exp_mis_flag));
            check("err_timeout", 32'(err_timeout), 32'(exp_to_flag));
        end
    endtask

    function automatic instr_t blank();
        instr_t t;
        t.v = 1'b1; t.alu = '0; t.wa = '0;
        t.rw = 0; t.mw = 0; t.mr = 0; t.m2r = 0; t.j = 0; t.br = 0; t.z = 0;
        t.baddr = '0; t.jaddr = '0; t.wdata = '0; t.d = 0;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int     kind, dsel;
        t = blank();
        kind  = $urandom_range(0, 3);
        t.v   = ($urandom_range(0, 7) != 0);
        t.alu = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 5) == 0) t.alu[1:0] = 2'($urandom_range(1, 3));
        t.wa    = 5'($urandom);
        t.m2r   = 1'($urandom);
        t.baddr = $urandom;
        t.jaddr = $urandom;
        t.wdata = $urandom;
        t.z     = 1'($urandom);
        case (kind)
            0: t.rw = 1'($urandom);
            1: begin t.mr = 1; t.rw = 1; end
            2: t.mw = 1;
            default: begin t.br = 1'($urandom); t.j = 1'($urandom); end
        endcase
        if (kind != 3 && $urandom_range(0, 4) == 0) begin t.j = 1; end
        dsel = $urandom_range(0, 9);
        if (dsel < 7)       t.d = $urandom_range(0, 4);
        else if (dsel < 9)  t.d = $urandom_range(TIMEOUT - 3, TIMEOUT + 1);
        else                t.d = NO_ACK;
        return t;
    endfunction

    initial begin
        instr_t t;

        // Reset state while RST is held from time zero.
        #3;
        check_reset_outputs("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // ALU op.
        t = blank(); t.rw = 1; t.wa = 5; t.alu = 32'h1234;
        run_instr(t);
        // Load at 0x100, ack after 3 wait cycles.
        t = blank(); t.mr = 1; t.rw = 1; t.m2r = 1; t.alu = 32'h100; t.wa = 7; t.d = 3;
        run_instr(t);
        // Store at 0x104 with immediate ack.
        t = blank(); t.mw = 1; t.alu = 32'h104; t.wdata = 32'hA5A5A5A5; t.d = 0;
        run_instr(t);
        // Ack on the exact timeout cycle: ack wins.
        t = blank(); t.mr = 1; t.rw = 1; t.alu = 32'h200; t.d = TIMEOUT - 1;
        run_instr(t);
        // Branch taken, then jump priority.
        t = blank(); t.br = 1; t.z = 1; t.baddr = 32'h40; t.jaddr = 32'h80;
        run_instr(t);
        t.j = 1;
        run_instr(t);
        // Misaligned load.
        t = blank(); t.mr = 1; t.rw = 1; t.alu = 32'h102; t.wa = 3;
        run_instr(t);
        // Load that never gets acked.
        t = blank(); t.mr = 1; t.rw = 1; t.alu = 32'h300; t.wa = 9; t.d = NO_ACK;
        run_instr(t);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            t = rand_instr();
            run_instr(t);
        end

        // Reset in the middle of an outstanding load.
        @(posedge CLK); #1;
        in_valid = 1; MemRead = 1; MemWrite = 0; RegWrite = 1; JtoPC = 0; Branch = 0;
        ALUresult = 32'h480; dm_ack = 0;
        repeat (3) @(negedge CLK);
        #2;
        check("midwait_req", 32'(dm_req), 1);
        RST = 1'b1;
        #1;
        check_reset_outputs("midwait_reset");
        exp_mis_flag = 1'b0;
        exp_to_flag  = 1'b0;
        @(posedge CLK); #1;
        in_valid = 0; MemRead = 0;
        RST = 1'b0;

        // Normal operation after reset.
        t = blank(); t.rw = 1; t.wa = 12; t.alu = 32'hCAFE0000;
        run_instr(t);
        t = blank(); t.mr = 1; t.rw = 1; t.alu = 32'h500; t.d = 1;
        run_instr(t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
